c3lib_rst_seq_ctrl: RTL and testbench

Staged reset-release sequencer for PHY sub-domains. The block releases NUM_STG active-low stage resets in order. Each stage must return an asynchronous ready/ack, which is synchronized internally by 2-stage reset-to-0 synchronizers, before a programmable delay elapses and the next stage is released. It sits between the top-level reset/enable control and the per-domain reset inputs, and reports completion or a per-stage timeout.

---
 rtl/c3lib_rst_seq_pkg.sv | 15 +
 rtl/c3lib_sync2_reset_ulvt_gate.sv | 22 ++
 rtl/c3lib_rst_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_c3lib_rst_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and widths for the staged reset-release sequencer.
package c3lib_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    DLY,
    DONE,
    ERR
  } seq_state_e;

  localparam int unsigned TMR_W = 12;
  localparam int unsigned DLY_W = 8;

endpackage

// File: rtl/c3lib_sync2_reset_ulvt_gate.sv
// Two-flop synchronizer, asynchronously reset to 0.
module c3lib_sync2_reset_ulvt_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input and resolve metastability over two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// Staged reset-release sequencer: releases stage resets in order, waiting
// for each stage's synchronized ack plus a fixed delay before the next.
module c3lib_rst_seq_ctrl
  import c3lib_rst_seq_pkg::*;
#(
  parameter int NUM_STG = 4,
  parameter int RLS_DLY = 16,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = $clog2(NUM_STG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seq_req,
  input  logic [NUM_STG-1:0] stg_ack_async,
  output logic [NUM_STG-1:0] stg_rst_n,
  output logic               seq_done,
  output logic               seq_err,
  output logic [IDX_W-1:0]   err_stg
);

  seq_state_e         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [DLY_W-1:0]   dly_cnt, dly_nxt;
  logic [NUM_STG-1:0] rst_nxt;
  logic               done_nxt, err_nxt;
  logic [IDX_W-1:0]   err_stg_nxt;
  logic [NUM_STG-1:0] ack_s;
  logic [IDX_W-1:0]   drop_idx;

  for (genvar g = 0; g < NUM_STG; g++) begin : g_ack_sync
    c3lib_sync2_reset_ulvt_gate u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stg_ack_async[g]),
      .q     (ack_s[g])
    );
  end

  // Lowest-numbered stage whose synchronized ack is low.
  always_comb begin
    drop_idx = '0;
    for (int unsigned i = NUM_STG; i > 0; i--) begin
      if (!ack_s[i-1]) drop_idx = IDX_W'(i - 1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      tmr       <= '0;
      dly_cnt   <= '0;
      stg_rst_n <= '0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
      err_stg   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      tmr       <= tmr_nxt;
      dly_cnt   <= dly_nxt;
      stg_rst_n <= rst_nxt;
      seq_done  <= done_nxt;
      seq_err   <= err_nxt;
      err_stg   <= err_stg_nxt;
    end
  end

  // Next-state and next-output logic; a dropped seq_req overrides everything.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    tmr_nxt     = tmr;
    dly_nxt     = dly_cnt;
    rst_nxt     = stg_rst_n;
    done_nxt    = seq_done;
    err_nxt     = seq_err;
    err_stg_nxt = err_stg;

    if (state != IDLE && !seq_req) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      tmr_nxt     = '0;
      dly_nxt     = '0;
      rst_nxt     = '0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      err_stg_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (seq_req) begin
            state_nxt = WAIT_ACK;
            idx_nxt   = '0;
            tmr_nxt   = '0;
            rst_nxt   = NUM_STG'(1);
          end
        end

        WAIT_ACK: begin
          if (tmr != '1) tmr_nxt = tmr + 1'b1;
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (ack_s[idx]) begin
            if (idx == IDX_W'(NUM_STG - 1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = DLY;
              dly_nxt   = DLY_W'(RLS_DLY - 1);
            end
          end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            state_nxt   = ERR;
            rst_nxt     = '0;
            done_nxt    = 1'b0;
            err_nxt     = 1'b1;
            err_stg_nxt = idx;
          end
        end

        DLY: begin
          if (dly_cnt == '0) begin
            state_nxt = WAIT_ACK;
            idx_nxt   = idx + 1'b1;
            tmr_nxt   = '0;
            rst_nxt   = stg_rst_n | (NUM_STG'(1) << (idx + 1'b1));
          end else begin
            dly_nxt = dly_cnt - 1'b1;
          end
        end

        DONE: begin
          if (!(&ack_s)) begin
            state_nxt   = ERR;
            rst_nxt     = '0;
            done_nxt    = 1'b0;
            err_nxt     = 1'b1;
            err_stg_nxt = drop_idx;
          end
        end

        ERR: begin
          rst_nxt  = '0;
          done_nxt = 1'b0;
          err_nxt  = 1'b1;
        end

        default: begin
          state_nxt   = IDLE;
          idx_nxt     = '0;
          tmr_nxt     = '0;
          dly_nxt     = '0;
          rst_nxt     = '0;
          done_nxt    = 1'b0;
          err_nxt     = 1'b0;
          err_stg_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3lib_rst_seq_ctrl.sv
// Directed bench for the staged reset-release sequencer (4 stages, 16-cycle
// release delay, 1024-cycle timeout).
module tb_c3lib_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seq_req;
  logic [3:0] stg_ack_async;
  logic [3:0] stg_rst_n;
  logic       seq_done;
  logic       seq_err;
  logic [1:0] err_stg;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned edge_n = 0;

  c3lib_rst_seq_ctrl #(
    .NUM_STG (4),
    .RLS_DLY (16),
    .TIMEOUT (1024)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seq_req       (seq_req),
    .stg_ack_async (stg_ack_async),
    .stg_rst_n     (stg_rst_n),
    .seq_done      (seq_done),
    .seq_err       (seq_err),
    .err_stg       (err_stg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [3:0]  ack;
    int unsigned n;
    logic [3:0]  rst;
    logic        done;
    logic        err;
    logic [1:0]  stg;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] rst, input logic done,
                           input logic err, input logic [1:0] stg);
    check({name, ".stg_rst_n"}, 32'(stg_rst_n), 32'(rst));
    check({name, ".seq_done"},  32'(seq_done),  32'(done));
    check({name, ".seq_err"},   32'(seq_err),   32'(err));
    check({name, ".err_stg"},   32'(err_stg),   32'(stg));
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst_n         = 1'b0;
    seq_req       = 1'b0;
    stg_ack_async = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    edge_n = 0;
  endtask

  task automatic wait_rise(input int unsigned bit_i, input int unsigned limit,
                           output int unsigned at);
    logic found;
    found = 1'b0;
    at    = 0;
    for (int unsigned k = 0; k < limit; k++) begin
      if (!found) begin
        step(1);
        if (stg_rst_n[bit_i]) begin
          found = 1'b1;
          at    = edge_n;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned at;
    logic        leaked;

    // Ack of stage k raised 5 edges after its release; edge counts in comments.
    vecs[0]  = '{1'b0, 4'b0000, 0,  4'b0000, 1'b0, 1'b0, 2'd0}; // reset state
    vecs[1]  = '{1'b1, 4'b0000, 1,  4'b0001, 1'b0, 1'b0, 2'd0}; // e1 stage0 out
    vecs[2]  = '{1'b1, 4'b0000, 5,  4'b0001, 1'b0, 1'b0, 2'd0}; // e6
    vecs[3]  = '{1'b1, 4'b0001, 2,  4'b0001, 1'b0, 1'b0, 2'd0}; // e8 ack_s seen
    vecs[4]  = '{1'b1, 4'b0001, 1,  4'b0001, 1'b0, 1'b0, 2'd0}; // e9 into delay
    vecs[5]  = '{1'b1, 4'b0001, 15, 4'b0001, 1'b0, 1'b0, 2'd0}; // e24 last wait
    vecs[6]  = '{1'b1, 4'b0001, 1,  4'b0011, 1'b0, 1'b0, 2'd0}; // e25 = 7+2+16
    vecs[7]  = '{1'b1, 4'b0001, 5,  4'b0011, 1'b0, 1'b0, 2'd0}; // e30
    vecs[8]  = '{1'b1, 4'b0011, 18, 4'b0011, 1'b0, 1'b0, 2'd0}; // e48
    vecs[9]  = '{1'b1, 4'b0011, 1,  4'b0111, 1'b0, 1'b0, 2'd0}; // e49 = 31+18
    vecs[10] = '{1'b1, 4'b0011, 5,  4'b0111, 1'b0, 1'b0, 2'd0}; // e54
    vecs[11] = '{1'b1, 4'b0111, 18, 4'b0111, 1'b0, 1'b0, 2'd0}; // e72
    vecs[12] = '{1'b1, 4'b0111, 1,  4'b1111, 1'b0, 1'b0, 2'd0}; // e73 = 55+18
    vecs[13] = '{1'b1, 4'b0111, 5,  4'b1111, 1'b0, 1'b0, 2'd0}; // e78
    vecs[14] = '{1'b1, 4'b1111, 2,  4'b1111, 1'b0, 1'b0, 2'd0}; // e80 ack_s[3]
    vecs[15] = '{1'b1, 4'b1111, 1,  4'b1111, 1'b1, 1'b0, 2'd0}; // e81 done
    vecs[16] = '{1'b1, 4'b1101, 2,  4'b1111, 1'b1, 1'b0, 2'd0}; // e83 drop not yet seen
    vecs[17] = '{1'b1, 4'b1101, 1,  4'b0000, 1'b0, 1'b1, 2'd1}; // e84 ack loss stage1
    vecs[18] = '{1'b0, 4'b1101, 1,  4'b0000, 1'b0, 1'b0, 2'd0}; // e85 back to idle
    vecs[19] = '{1'b0, 4'b0000, 3,  4'b0000, 1'b0, 1'b0, 2'd0}; // stays idle

    // Reset values while rst_n is held low.
    rst_n         = 1'b0;
    seq_req       = 1'b0;
    stg_ack_async = 4'b0000;
    #1;
    check_all("in_reset", 4'b0000, 1'b0, 1'b0, 2'd0);

    reset_dut();
    for (int unsigned i = 0; i < 20; i++) begin
      seq_req       = vecs[i].req;
      stg_ack_async = vecs[i].ack;
      step(vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].rst, vecs[i].done, vecs[i].err, vecs[i].stg);
    end

    // Stage 2 never acks: error exactly TIMEOUT edges after its release.
    reset_dut();
    seq_req       = 1'b1;
    stg_ack_async = 4'b0011;
    wait_rise(2, 100, at);
    check("tmo.rel2_edge", 32'(at), 32'd36);
    step(1023);
    check_all("tmo.pre", 4'b0111, 1'b0, 1'b0, 2'd0);
    step(1);
    check_all("tmo.err", 4'b0000, 1'b0, 1'b1, 2'd2);
    seq_req = 1'b0;
    step(1);
    check_all("tmo.clr", 4'b0000, 1'b0, 1'b0, 2'd0);

    // Ack synchronized in the same cycle the timer hits TIMEOUT-1: ack wins.
    reset_dut();
    seq_req       = 1'b1;
    stg_ack_async = 4'b0011;
    wait_rise(2, 100, at);
    check("race.rel2_edge", 32'(at), 32'd36);
    step(1021);
    stg_ack_async = 4'b0111;
    step(2);
    check_all("race.pre", 4'b0111, 1'b0, 1'b0, 2'd0);
    step(1);
    check_all("race.edge", 4'b0111, 1'b0, 1'b0, 2'd0);
    step(15);
    check("race.rel3_early", 32'(stg_rst_n), 32'h7);
    step(1);
    check("race.rel3", 32'(stg_rst_n), 32'hF);
    stg_ack_async = 4'b1111;
    step(3);
    check_all("race.done", 4'b1111, 1'b1, 1'b0, 2'd0);

    // seq_req dropped while delaying after the stage-1 ack.
    reset_dut();
    seq_req       = 1'b1;
    stg_ack_async = 4'b0011;
    wait_rise(1, 100, at);
    check("abort.rel1_edge", 32'(at), 32'd19);
    step(6);
    check("abort.pre", 32'(stg_rst_n), 32'h3);
    seq_req = 1'b0;
    step(1);
    check_all("abort.drop", 4'b0000, 1'b0, 1'b0, 2'd0);
    leaked = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      step(1);
      if (stg_rst_n != 4'b0000) leaked = 1'b1;
    end
    check("abort.no_release", 32'(leaked), 32'd0);
    seq_req = 1'b1;
    step(1);
    check("abort.restart", 32'(stg_rst_n), 32'h1);

    // Async reset in stage-2 WAIT_ACK, then restart from stage 0.
    reset_dut();
    seq_req       = 1'b1;
    stg_ack_async = 4'b0011;
    wait_rise(2, 100, at);
    check("arst.rel2_edge", 32'(at), 32'd36);
    step(4);
    check("arst.pre", 32'(stg_rst_n), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst.async", 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    step(1);
    check_all("arst.restart", 4'b0001, 1'b0, 1'b0, 2'd0);
    wait_rise(1, 100, at);
    check("arst.rel1_edge", 32'(at), 32'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
